mem_refill_arbiter: RTL and testbench

//  Shares one word-wide main-memory port between the data-cache miss engine (D port) and the instruction-fetch refill path (I port).

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_refill_arbiter.sv | 112 +++++++++++
 tb/tb_mem_refill_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the cache-to-main-memory refill path.
package cpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} owner_t;

  // Clears the word-in-line and byte offset bits of a line address.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_words);
    logic [31:0] mask;
    mask = 32'(line_words) * 32'd4 - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way requester chooser: fixed D priority or round-robin against the last grant.
module mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter bit DCACHE_PRIO = 1'b1
) (
  input  logic   d_req,
  input  logic   i_req,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant_owner
);

  always_comb begin
    grant_valid = d_req | i_req;
    grant_owner = OWN_D;
    if (d_req && i_req) begin
      // A tie in round-robin mode goes to whoever was not served last.
      if (!DCACHE_PRIO && last_grant == OWN_D) grant_owner = OWN_I;
    end else if (i_req) begin
      grant_owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one word-wide memory port between the D-cache miss engine and I-fetch refill,
// moving one full line per grant and signalling completion with a one-cycle done pulse.
module mem_refill_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int LINE_WORDS  = 8,
  parameter bit DCACHE_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_done,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  localparam int BEAT_W = $clog2(LINE_WORDS);

  state_t              state;
  owner_t              owner;
  owner_t              last_grant;
  logic                owner_we;
  logic [31:0]         base;
  logic [BEAT_W-1:0]   beat;
  logic                grant_valid;
  owner_t              grant_owner;

  mem_arb_pick #(
    .DCACHE_PRIO(DCACHE_PRIO)
  ) u_pick (
    .d_req      (d_req),
    .i_req      (i_req),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_D;
      last_grant <= OWN_I;
      owner_we   <= 1'b0;
      base       <= '0;
      beat       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner    <= grant_owner;
            owner_we <= (grant_owner == OWN_D) && d_we;
            base     <= line_base((grant_owner == OWN_D) ? d_addr : i_addr, LINE_WORDS);
            beat     <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (beat == BEAT_W'(LINE_WORDS - 1)) state <= DONE;
          end
        end
        DONE: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic xfer;
  logic ack;
  logic own_d;

  assign xfer  = (state == XFER);
  assign ack   = xfer && mem_ack;
  assign own_d = (owner == OWN_D);

  // The beat index fills the offset bits directly, so the address wraps inside the line.
  assign mem_req   = xfer;
  assign mem_we    = xfer && owner_we;
  assign mem_addr  = xfer ? (base | {{(30 - BEAT_W){1'b0}}, beat, 2'b00}) : 32'h0;
  assign mem_wdata = (xfer && own_d) ? d_wdata : 32'h0;

  assign d_wready = ack && owner_we;
  assign d_rvalid = ack && own_d && !owner_we;
  assign i_rvalid = ack && !own_d;
  assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;
  assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;

  assign d_done = (state == DONE) && own_d;
  assign i_done = (state == DONE) && !own_d;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Scoreboard bench for mem_refill_arbiter: fixed-priority DUT for most vectors, round-robin DUT for grant order.
module tb_mem_refill_arbiter;

  localparam int LW = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        port_i;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Priority DUT signals
  logic        d_req_a = 0, d_we_a = 0, i_req_a = 0;
  logic [31:0] d_addr_a = 0, i_addr_a = 0, d_wdata_a;
  logic        d_wready_a, d_rvalid_a, d_done_a, i_rvalid_a, i_done_a;
  logic [31:0] d_rdata_a, i_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        mem_req_a, mem_we_a, mem_ack_a, busy_a;

  // Round-robin DUT signals
  logic        d_req_b = 0, i_req_b = 0;
  logic        d_wready_b, d_rvalid_b, d_done_b, i_rvalid_b, i_done_b;
  logic [31:0] d_rdata_b, i_rdata_b, mem_addr_b, mem_wdata_b;
  logic        mem_req_b, mem_we_b, busy_b;

  mem_refill_arbiter #(.LINE_WORDS(LW), .DCACHE_PRIO(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_wready(d_wready_a), .d_rdata(d_rdata_a), .d_rvalid(d_rvalid_a), .d_done(d_done_a),
    .i_req(i_req_a), .i_addr(i_addr_a), .i_rdata(i_rdata_a), .i_rvalid(i_rvalid_a), .i_done(i_done_a),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .mem_ack(mem_ack_a), .busy(busy_a)
  );

  mem_refill_arbiter #(.LINE_WORDS(LW), .DCACHE_PRIO(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .d_req(d_req_b), .d_we(1'b0), .d_addr(32'h0000_0100), .d_wdata(32'h0),
    .d_wready(d_wready_b), .d_rdata(d_rdata_b), .d_rvalid(d_rvalid_b), .d_done(d_done_b),
    .i_req(i_req_b), .i_addr(32'h0000_0200), .i_rdata(i_rdata_b), .i_rvalid(i_rvalid_b), .i_done(i_done_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(32'h0), .mem_ack(mem_req_b), .busy(busy_b)
  );

  // Memory model for DUT A: programmable ack latency, address-derived read data, optional stray ack
  int   ack_delay = 0;
  int   wait_cnt;
  logic stray_ack = 1'b0;
  assign mem_ack_a   = (mem_req_a && (wait_cnt >= ack_delay)) || stray_ack;
  assign mem_rdata_a = 32'hD000_0000 ^ mem_addr_a;
  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 0;
    else if (mem_req_a && !mem_ack_a) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // D-side writeback source: next word appears the cycle after each d_wready
  logic [31:0] wbeat;
  assign d_wdata_a = 32'hA0 + wbeat;
  always @(posedge clk) begin
    if (!d_req_a) wbeat <= 0;
    else if (d_wready_a) wbeat <= wbeat + 1;
  end

  logic [135:0] outs_a;
  assign outs_a = {d_wready_a, d_rdata_a, d_rvalid_a, d_done_a, i_rdata_a, i_rvalid_a, i_done_a,
                   mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a, busy_a};

  int checks = 0;
  int errors = 0;
  beat_t      exp_beat[$];
  logic [1:0] exp_done[$];
  logic [1:0] exp_done_b[$];
  logic       prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs_zero(input string name);
    chk({name, "_hi"}, outs_a[135:72], 64'h0);
    chk({name, "_mid"}, outs_a[71:8], 64'h0);
    chk({name, "_lo"}, 64'(outs_a[7:0]), 64'h0);
  endtask

  task automatic push_line(input bit port_i, input bit we, input logic [31:0] base);
    beat_t e;
    for (int b = 0; b < LW; b++) begin
      e.addr   = base + 32'(4 * b);
      e.we     = we;
      e.port_i = port_i;
      e.wdata  = port_i ? 32'h0 : (we ? 32'hA0 + 32'(b) : 32'hA0);
      exp_beat.push_back(e);
    end
    exp_done.push_back(port_i ? 2'b01 : 2'b10);
  endtask

  // Monitor for DUT A
  always @(negedge clk) begin
    if (rst) begin
      beat_t e;
      logic [31:0] rd;
      if (prev_done) chk("idle_gap_after_done", 64'({busy_a, mem_req_a}), 64'h0);
      prev_done <= d_done_a || i_done_a;
      if (mem_req_a && mem_ack_a) begin
        if (exp_beat.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: addr %0h with empty queue", mem_addr_a);
        end else begin
          e  = exp_beat.pop_front();
          rd = 32'hD000_0000 ^ e.addr;
          chk("mem_addr", 64'(mem_addr_a), 64'(e.addr));
          chk("mem_we_wdata", 64'({mem_we_a, mem_wdata_a}), 64'({e.we, e.wdata}));
          chk("strobes", 64'({d_rvalid_a, d_wready_a, i_rvalid_a}),
              64'({!e.port_i && !e.we, !e.port_i && e.we, e.port_i}));
          chk("rdata", {d_rdata_a, i_rdata_a},
              {(e.port_i || e.we) ? 32'h0 : rd, e.port_i ? rd : 32'h0});
        end
      end else begin
        chk("no_strobe_without_ack", 64'({d_rvalid_a, i_rvalid_a, d_wready_a}), 64'h0);
      end
      if (d_done_a || i_done_a) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: d=%0b i=%0b", d_done_a, i_done_a);
        end else begin
          chk("done_port", 64'({d_done_a, i_done_a}), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  // Monitor for DUT B
  always @(negedge clk) begin
    if (rst && (d_done_b || i_done_b)) begin
      if (exp_done_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done_b: d=%0b i=%0b", d_done_b, i_done_b);
      end else begin
        chk("grant_order_b", 64'({d_done_b, i_done_b}), 64'(exp_done_b.pop_front()));
      end
    end
  end

  task automatic wait_done(input bit port_i, input int budget, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (port_i ? i_done_a : d_done_a) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: port_i=%0b no done within %0d cycles", port_i, budget);
    end
  endtask

  task automatic wait_addr(input logic [31:0] addr, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk); #1;
      if (mem_req_a && mem_addr_a == addr) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL addr_timeout: mem_addr %0h never presented, required %0h", mem_addr_a, addr);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (exp_beat.size() == 0 && exp_done.size() == 0 && exp_done_b.size() == 0) break;
    end
    chk("queues_drained", 64'(exp_beat.size() + exp_done.size() + exp_done_b.size()), 64'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset with requests asserted: every output held at zero
    d_req_a = 1; i_req_a = 1; d_addr_a = 32'h0000_1234;
    #12;
    chk_outs_zero("reset_outs");
    d_req_a = 0; i_req_a = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'(busy_a), 64'h0);

    // Stray acks while idle are ignored
    stray_ack = 1;
    repeat (3) @(posedge clk);
    #1;
    stray_ack = 0;
    chk("stray_ack_idle", 64'({busy_a, mem_req_a}), 64'h0);

    // 1: D refill of 0x1234, ack every cycle, done on the tenth cycle
    push_line(0, 0, 32'h0000_1220);
    d_we_a = 0; d_addr_a = 32'h0000_1234; d_req_a = 1;
    wait_done(0, 40, n);
    d_req_a = 0;
    chk("d_done_latency", 64'(n), 64'(LW + 2));
    wait_drain(40);

    // 2: simultaneous D and I, D wins, I follows after one idle cycle
    push_line(0, 0, 32'h0000_2040);
    push_line(1, 0, 32'h0000_3000);
    d_addr_a = 32'h0000_2048; i_addr_a = 32'h0000_3010;
    d_req_a = 1; i_req_a = 1;
    wait_done(0, 40, n);
    d_req_a = 0;
    wait_done(1, 40, n);
    i_req_a = 0;
    wait_drain(40);

    // 3: round-robin DUT, both held for four transfers
    exp_done_b.push_back(2'b10);
    exp_done_b.push_back(2'b01);
    exp_done_b.push_back(2'b10);
    exp_done_b.push_back(2'b01);
    d_req_b = 1; i_req_b = 1;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (exp_done_b.size() == 0) break;
    end
    d_req_b = 0; i_req_b = 0;
    wait_drain(10);
    chk("rr_idle_after", 64'(busy_b), 64'h0);

    // 4: writeback with 3-cycle ack latency per beat
    ack_delay = 3;
    push_line(0, 1, 32'h0000_8000);
    d_we_a = 1; d_addr_a = 32'h0000_8004; d_req_a = 1;
    wait_done(0, 100, n);
    d_req_a = 0; d_we_a = 0;
    ack_delay = 0;
    wait_drain(20);

    // 5: reset at beat 4 of an I refill, then a clean restart
    push_line(1, 0, 32'h0000_4000);
    i_addr_a = 32'h0000_401C; i_req_a = 1;
    wait_addr(32'h0000_4010, 40);
    rst = 0;
    #1;
    chk_outs_zero("async_rst_outs");
    chk("beats_left_at_rst", 64'(exp_beat.size()), 64'(4));
    exp_beat.delete();
    exp_done.delete();
    i_req_a = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_in_rst", 64'(busy_a), 64'h0);
    rst = 1;
    @(posedge clk); #1;
    chk("idle_after_rst_release", 64'(busy_a), 64'h0);
    push_line(1, 0, 32'h0000_4000);
    i_req_a = 1;
    wait_done(1, 40, n);
    i_req_a = 0;
    wait_drain(40);

    // 6: I request withdrawn mid-line still completes; D waits its turn
    push_line(1, 0, 32'h0000_6000);
    push_line(0, 0, 32'h0000_5F20);
    i_addr_a = 32'h0000_6004; i_req_a = 1;
    wait_addr(32'h0000_6008, 40);
    i_req_a = 0;
    wait_addr(32'h0000_600C, 40);
    d_addr_a = 32'h0000_5F3C; d_req_a = 1;
    wait_done(0, 60, n);
    d_req_a = 0;
    wait_drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
